// File: rtl/lock_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// lock_pkg
// Shared types and timing constants for the lock controller blocks.
//   seq_state_t : factory-reset sequencer state encoding (also exported on
//                 the debug state_o port, so the values are fixed)
//   CLK_FREQ_HZ : system clock frequency used by every timing block
//   max3        : helper for sizing shared counters from several limits
// -----------------------------------------------------------------------------
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HOLD     = 3'd1,
    CLEAR    = 3'd2,
    CLR_REL  = 3'd3,
    SETUP    = 3'd4,
    DONE     = 3'd5,
    ERR      = 3'd6,
    WAIT_REL = 3'd7
  } seq_state_t;

  localparam int CLK_FREQ_HZ = 1000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cycle_timer
// Loadable down-counter that saturates at zero. Intended to be shared by the
// lock's timing blocks (factory reset, lockout, door-open).
//
// Ports
//   clk       in  1  system clock
//   rst_n     in  1  asynchronous reset, active low (count cleared to 0)
//   load      in  1  load load_val this cycle (takes priority over counting)
//   load_val  in  W  value loaded into the counter
//   expired   out 1  counter currently at zero
//
// A value of N loaded on one edge makes expired rise N cycles later, so a
// window of N+1 cycles is obtained by loading N.
// -----------------------------------------------------------------------------
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign expired = (r_cnt == '0);

endmodule

// File: rtl/factory_reset_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// factory_reset_seq
// Sequences the lock's factory-reset procedure from the front-panel key:
// the key must be held for HOLD_S seconds, then the stored-PIN memory is
// cleared through a 4-phase req/ack handshake, then the lock sits in setup
// mode until a new master PIN is entered or SETUP_TIMEOUT_S expires.
// Sits between the debounced keypad front end and the PIN storage / main
// lock FSM.
//
// Parameters
//   CLK_FREQ_HZ      system clock frequency, Hz
//   HOLD_S           required key hold time, s
//   CLR_TIMEOUT_MS   max wait for each handshake phase, ms (at least 1 cycle)
//   SETUP_TIMEOUT_S  max time in setup mode, s
//
// Ports
//   clk          in   1  system clock
//   rst_n        in   1  asynchronous reset, active low
//   btn_reset    in   1  debounced, synchronised reset key level
//   clr_ack      in   1  storage clear acknowledge (4-phase)
//   pin_valid    in   1  pulse: new master PIN entered and valid
//   hold_active  out  1  high while the key hold is being timed (panel LED)
//   clr_req      out  1  storage clear request (4-phase)
//   setup_mode   out  1  high while waiting for the new master PIN
//   pin_commit   out  1  pulse: store the entered PIN as master
//   seq_done     out  1  pulse: sequence completed
//   seq_error    out  1  pulse: sequence aborted on a timeout
//   state_o      out  3  current state encoding (debug)
//
// All outputs except pin_commit are decoded from the state register only.
// pin_commit is Mealy so the PIN is stored in the same cycle it is reported
// valid.
// -----------------------------------------------------------------------------
module factory_reset_seq #(
  parameter int CLK_FREQ_HZ     = lock_pkg::CLK_FREQ_HZ,
  parameter int HOLD_S          = 5,
  parameter int CLR_TIMEOUT_MS  = 100,
  parameter int SETUP_TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_reset,
  input  logic       clr_ack,
  input  logic       pin_valid,
  output logic       hold_active,
  output logic       clr_req,
  output logic       setup_mode,
  output logic       pin_commit,
  output logic       seq_done,
  output logic       seq_error,
  output logic [2:0] state_o
);

  import lock_pkg::*;

  localparam int HOLD_CYC  = HOLD_S * CLK_FREQ_HZ;
  localparam int CLR_RAW   = (CLR_TIMEOUT_MS * CLK_FREQ_HZ) / 1000;
  // A sub-cycle handshake timeout still has to allow one sampling cycle.
  localparam int CLR_CYC   = (CLR_RAW < 1) ? 1 : CLR_RAW;
  localparam int SETUP_CYC = SETUP_TIMEOUT_S * CLK_FREQ_HZ;
  localparam int MAX_CYC   = max3(HOLD_CYC, CLR_CYC, SETUP_CYC);
  localparam int TW        = $clog2(MAX_CYC + 1);

  // Loaded with CYC-1 because the state itself occupies the cycle in which
  // the timer reads zero, giving exactly CYC cycles in the state.
  localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] CLR_LD   = TW'(CLR_CYC - 1);
  localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYC - 1);

  seq_state_t    r_state;
  seq_state_t    w_next;
  logic          w_load;
  logic [TW-1:0] w_load_val;
  logic          w_expired;

  // ---------------------------------------------------------------------------
  // Shared phase timer
  // ---------------------------------------------------------------------------
  cycle_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (w_load_val),
    .expired  (w_expired)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (btn_reset) w_next = HOLD;
      end
      HOLD: begin
        // Checking release first makes a release in the expiry cycle abort.
        if (!btn_reset)     w_next = IDLE;
        else if (w_expired) w_next = CLEAR;
      end
      CLEAR: begin
        // Ack is checked first so it wins over a same-cycle timeout.
        if (clr_ack)        w_next = CLR_REL;
        else if (w_expired) w_next = ERR;
      end
      CLR_REL: begin
        if (!clr_ack)       w_next = SETUP;
        else if (w_expired) w_next = ERR;
      end
      SETUP: begin
        // A PIN arriving in the last setup cycle is still accepted.
        if (pin_valid)      w_next = DONE;
        else if (w_expired) w_next = ERR;
      end
      DONE:     w_next = WAIT_REL;
      ERR:      w_next = WAIT_REL;
      WAIT_REL: begin
        // The key must be released before another sequence can start.
        if (!btn_reset) w_next = IDLE;
      end
      default:  w_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Timer reload on every state change, value chosen by the state entered
  // ---------------------------------------------------------------------------
  always_comb begin
    w_load     = (w_next != r_state);
    w_load_val = '0;
    case (w_next)
      HOLD:    w_load_val = HOLD_LD;
      CLEAR:   w_load_val = CLR_LD;
      CLR_REL: w_load_val = CLR_LD;
      SETUP:   w_load_val = SETUP_LD;
      default: w_load_val = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    hold_active = 1'b0;
    clr_req     = 1'b0;
    setup_mode  = 1'b0;
    pin_commit  = 1'b0;
    seq_done    = 1'b0;
    seq_error   = 1'b0;
    case (r_state)
      HOLD:  hold_active = 1'b1;
      CLEAR: clr_req     = 1'b1;
      SETUP: begin
        setup_mode = 1'b1;
        pin_commit = pin_valid;
      end
      DONE:  seq_done    = 1'b1;
      ERR:   seq_error   = 1'b1;
      default: ;
    endcase
  end

  assign state_o = r_state;

endmodule

// File: tb/tb_factory_reset_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_factory_reset_seq
// Table-driven bench for factory_reset_seq with fast timing parameters:
// CLK_FREQ_HZ=10, HOLD_S=1, CLR_TIMEOUT_MS=500, SETUP_TIMEOUT_S=2, giving a
// 10-cycle hold, 5-cycle handshake phases and a 20-cycle setup window.
// Each table row drives inputs for n cycles; the outputs observed in each of
// those cycles (state from the previous edge, pin_commit from the current
// inputs) must match the row's expected vector.
// Output vector layout: {state[2:0], hold_active, clr_req, setup_mode,
// pin_commit, seq_done, seq_error}.
// -----------------------------------------------------------------------------
module tb_factory_reset_seq;

  localparam logic [2:0] S_IDLE = 3'd0, S_HOLD = 3'd1, S_CLEAR = 3'd2,
                         S_CREL = 3'd3, S_SETUP = 3'd4, S_DONE = 3'd5,
                         S_ERR  = 3'd6, S_WREL  = 3'd7;

  localparam logic [5:0] O_NONE = 6'b000000, O_HA = 6'b100000,
                         O_RQ   = 6'b010000, O_SM = 6'b001000,
                         O_PC   = 6'b000100, O_DN = 6'b000010,
                         O_ER   = 6'b000001;

  typedef struct {
    int         n;
    logic       b;
    logic       a;
    logic       p;
    logic [8:0] exp;
    string      nm;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_reset;
  logic       clr_ack;
  logic       pin_valid;
  logic       hold_active;
  logic       clr_req;
  logic       setup_mode;
  logic       pin_commit;
  logic       seq_done;
  logic       seq_error;
  logic [2:0] state_o;

  int         checks = 0;
  int         errors = 0;
  vec_t       tbl[$];
  logic [8:0] sb[$];

  factory_reset_seq #(
    .CLK_FREQ_HZ     (10),
    .HOLD_S          (1),
    .CLR_TIMEOUT_MS  (500),
    .SETUP_TIMEOUT_S (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_reset   (btn_reset),
    .clr_ack     (clr_ack),
    .pin_valid   (pin_valid),
    .hold_active (hold_active),
    .clr_req     (clr_req),
    .setup_mode  (setup_mode),
    .pin_commit  (pin_commit),
    .seq_done    (seq_done),
    .seq_error   (seq_error),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] got_vec();
    return {state_o, hold_active, clr_req, setup_mode, pin_commit, seq_done, seq_error};
  endfunction

  function automatic void add(input int n, input logic b, input logic a, input logic p,
                              input logic [2:0] st, input logic [5:0] o, input string nm);
    vec_t v;
    v.n = n; v.b = b; v.a = a; v.p = p; v.exp = {st, o}; v.nm = nm;
    tbl.push_back(v);
  endfunction

  task automatic compare(input string nm, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got st=%0d out=%b required st=%0d out=%b",
               nm, $time, got[8:6], got[5:0], exp[8:6], exp[5:0]);
    end
  endtask

  // One clock cycle: drive at the falling edge, expected result queued with
  // the stimulus, DUT output sampled 1ns later and checked against the queue.
  task automatic step(input logic b, input logic a, input logic p,
                      input logic [8:0] exp, input string nm);
    logic [8:0] e;
    @(negedge clk);
    btn_reset = b;
    clr_ack   = a;
    pin_valid = p;
    sb.push_back(exp);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      compare(nm, got_vec(), e);
    end
  endtask

  initial begin
    // Full pass with the key held through the whole sequence
    add(1,  1,0,0, S_IDLE,  O_NONE,      "full_idle");
    add(10, 1,0,0, S_HOLD,  O_HA,        "full_hold");
    add(2,  1,0,0, S_CLEAR, O_RQ,        "full_req");
    add(1,  1,1,0, S_CLEAR, O_RQ,        "full_ack");
    add(1,  1,1,0, S_CREL,  O_NONE,      "full_req_drop");
    add(1,  1,0,0, S_CREL,  O_NONE,      "full_ack_low");
    add(2,  1,0,0, S_SETUP, O_SM,        "full_setup");
    add(1,  1,0,1, S_SETUP, O_SM | O_PC, "full_commit");
    add(1,  1,0,0, S_DONE,  O_DN,        "full_done");
    add(2,  1,0,0, S_WREL,  O_NONE,      "full_wait_held");
    add(1,  0,0,0, S_WREL,  O_NONE,      "full_release");
    add(1,  0,0,0, S_IDLE,  O_NONE,      "full_back_idle");
    // Short press, then stray ack/pin_valid in IDLE must be ignored
    add(1,  1,0,0, S_IDLE,  O_NONE,      "short_idle");
    add(8,  1,0,0, S_HOLD,  O_HA,        "short_hold");
    add(1,  0,0,0, S_HOLD,  O_HA,        "short_release");
    add(2,  0,1,1, S_IDLE,  O_NONE,      "short_ignored");
    // Ack never arrives
    add(1,  1,0,0, S_IDLE,  O_NONE,      "acktmo_idle");
    add(10, 1,0,0, S_HOLD,  O_HA,        "acktmo_hold");
    add(5,  0,0,0, S_CLEAR, O_RQ,        "acktmo_req");
    add(1,  0,0,0, S_ERR,   O_ER,        "acktmo_err");
    add(1,  0,0,0, S_WREL,  O_NONE,      "acktmo_wrel");
    add(1,  0,0,0, S_IDLE,  O_NONE,      "acktmo_idle2");
    // Setup window runs out; pin_valid in ERR must not commit
    add(1,  1,0,0, S_IDLE,  O_NONE,      "setmo_idle");
    add(10, 1,0,0, S_HOLD,  O_HA,        "setmo_hold");
    add(1,  0,1,0, S_CLEAR, O_RQ,        "setmo_ack");
    add(1,  0,0,0, S_CREL,  O_NONE,      "setmo_crel");
    add(20, 0,0,0, S_SETUP, O_SM,        "setmo_setup");
    add(1,  0,0,1, S_ERR,   O_ER,        "setmo_err");
    add(1,  0,0,0, S_WREL,  O_NONE,      "setmo_wrel");
    add(1,  0,0,0, S_IDLE,  O_NONE,      "setmo_idle2");
    // Tie-breaks: ack in the last CLEAR cycle, pin_valid in the last SETUP cycle
    add(1,  1,0,0, S_IDLE,  O_NONE,      "tie_idle");
    add(10, 1,0,0, S_HOLD,  O_HA,        "tie_hold");
    add(4,  0,0,0, S_CLEAR, O_RQ,        "tie_req");
    add(1,  0,1,0, S_CLEAR, O_RQ,        "tie_ack_last");
    add(1,  0,0,0, S_CREL,  O_NONE,      "tie_crel");
    add(19, 0,0,0, S_SETUP, O_SM,        "tie_setup");
    add(1,  0,0,1, S_SETUP, O_SM | O_PC, "tie_pin_last");
    add(1,  0,0,0, S_DONE,  O_DN,        "tie_done");
    add(1,  0,0,0, S_WREL,  O_NONE,      "tie_wrel");
    add(1,  0,0,0, S_IDLE,  O_NONE,      "tie_idle2");
    // Ack stuck high in the release phase
    add(1,  1,0,0, S_IDLE,  O_NONE,      "reltmo_idle");
    add(10, 1,0,0, S_HOLD,  O_HA,        "reltmo_hold");
    add(1,  0,1,0, S_CLEAR, O_RQ,        "reltmo_ack");
    add(5,  0,1,0, S_CREL,  O_NONE,      "reltmo_crel");
    add(1,  0,1,0, S_ERR,   O_ER,        "reltmo_err");
    add(1,  0,0,0, S_WREL,  O_NONE,      "reltmo_wrel");
    add(1,  0,0,0, S_IDLE,  O_NONE,      "reltmo_idle2");
    // Release sampled in the hold expiry cycle aborts
    add(1,  1,0,0, S_IDLE,  O_NONE,      "holdtie_idle");
    add(9,  1,0,0, S_HOLD,  O_HA,        "holdtie_hold");
    add(1,  0,0,0, S_HOLD,  O_HA,        "holdtie_last");
    add(2,  0,0,0, S_IDLE,  O_NONE,      "holdtie_idle2");

    // Reset state
    rst_n     = 1'b0;
    btn_reset = 1'b0;
    clr_ack   = 1'b0;
    pin_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    compare("reset_state", got_vec(), {S_IDLE, O_NONE});
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        step(tbl[i].b, tbl[i].a, tbl[i].p, tbl[i].exp, tbl[i].nm);
      end
    end

    // Asynchronous reset in the middle of the clear handshake
    step(1, 0, 0, {S_IDLE, O_NONE}, "arst_idle");
    repeat (10) step(1, 0, 0, {S_HOLD, O_HA}, "arst_hold");
    step(1, 0, 0, {S_CLEAR, O_RQ}, "arst_req");
    #1;
    rst_n = 1'b0;
    #1;
    compare("arst_immediate", got_vec(), {S_IDLE, O_NONE});
    @(negedge clk);
    #1;
    compare("arst_held", got_vec(), {S_IDLE, O_NONE});
    btn_reset = 1'b0;
    rst_n     = 1'b1;
    step(0, 0, 0, {S_IDLE, O_NONE}, "arst_release");
    step(0, 0, 0, {S_IDLE, O_NONE}, "arst_stay_idle");

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #100000;
    $display("FAIL watchdog t=%0t required finish before timeout", $time);
    $fatal(1, "watchdog");
  end

endmodule
